// File: rtl/mxv_result_collector.sv
// Collects lane beats from the banded matrix-by-vector unit into the cluster result vector.
// It drops the zero-padded tail rows and flags completion and any overrun beats.
module mxv_result_collector #(
    parameter int no_of_eqn_per_cluster = 10,
    parameter int element_width         = 32,
    parameter int no_of_units           = 4,
    localparam int total_beats = (no_of_eqn_per_cluster + no_of_units - 1) / no_of_units,
    localparam int count_width = $clog2(total_beats + 1)
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic                                            start,
    input  logic                                            in_valid,
    input  logic [element_width*no_of_units-1:0]            in_data,
    output logic [element_width*no_of_eqn_per_cluster-1:0]  result_vector,
    output logic [count_width-1:0]                          beat_count,
    output logic                                            done,
    output logic                                            extra_beat
);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DONE
    } state_t;

    state_t                                           state_q, state_d;
    logic [element_width*no_of_eqn_per_cluster-1:0]   result_vector_q, result_vector_d;
    logic [count_width-1:0]                           beat_count_q, beat_count_d;
    logic                                             done_q, done_d;
    logic                                             extra_beat_q, extra_beat_d;

    logic                                             accept;
    logic [count_width-1:0]                           beat_idx;

    always_comb begin
        state_d         = state_q;
        result_vector_d = result_vector_q;
        beat_count_d    = beat_count_q;
        done_d          = done_q;
        extra_beat_d    = extra_beat_q;
        accept          = 1'b0;
        beat_idx        = beat_count_q;

        case (state_q)
            IDLE: begin
                beat_count_d = '0;
                done_d       = 1'b0;
                extra_beat_d = 1'b0;
                beat_idx     = '0;
                // A fresh session wipes the old vector; a beat on the same edge is beat 0.
                if (start) begin
                    state_d         = COLLECT;
                    result_vector_d = '0;
                    accept          = in_valid;
                end
            end
            COLLECT: begin
                if (!start) begin
                    state_d      = IDLE;
                    beat_count_d = '0;
                    done_d       = 1'b0;
                end else begin
                    accept = in_valid;
                end
            end
            DONE: begin
                if (!start) begin
                    state_d      = IDLE;
                    beat_count_d = '0;
                    done_d       = 1'b0;
                    extra_beat_d = 1'b0;
                end else if (in_valid) begin
                    extra_beat_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Row r is lane (r mod units) of beat (r div units); rows past the cluster never exist.
        if (accept) begin
            for (int r = 0; r < no_of_eqn_per_cluster; r++) begin
                if (int'(beat_idx) == r / no_of_units) begin
                    result_vector_d[element_width*(no_of_eqn_per_cluster-r)-1 -: element_width] =
                        in_data[element_width*(no_of_units-(r % no_of_units))-1 -: element_width];
                end
            end
            beat_count_d = beat_idx + count_width'(1);
            if (beat_idx == count_width'(total_beats - 1)) begin
                state_d = DONE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            result_vector_q <= '0;
            beat_count_q    <= '0;
            done_q          <= 1'b0;
            extra_beat_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            result_vector_q <= result_vector_d;
            beat_count_q    <= beat_count_d;
            done_q          <= done_d;
            extra_beat_q    <= extra_beat_d;
        end
    end

    assign result_vector = result_vector_q;
    assign beat_count    = beat_count_q;
    assign done          = done_q;
    assign extra_beat    = extra_beat_q;

endmodule

// File: tb/tb_mxv_result_collector.sv
// Bench for mxv_result_collector: scenario tasks plus a randomized run against a row-array model.
// A second instance covers the case where the cluster size divides evenly into lanes.
module tb_mxv_result_collector;

    localparam int N   = 10;
    localparam int EW  = 32;
    localparam int U   = 4;
    localparam int NB  = 3;
    localparam int CW  = $clog2(NB + 1);
    localparam int N8  = 8;
    localparam int NB8 = 2;
    localparam int CW8 = $clog2(NB8 + 1);

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              in_valid;
    logic [EW*U-1:0]   in_data;
    logic [EW*N-1:0]   result_vector;
    logic [CW-1:0]     beat_count;
    logic              done;
    logic              extra_beat;

    logic              start8;
    logic              in_valid8;
    logic [EW*U-1:0]   in_data8;
    logic [EW*N8-1:0]  result_vector8;
    logic [CW8-1:0]    beat_count8;
    logic              done8;
    logic              extra_beat8;

    int errors = 0;
    int checks = 0;

    logic [EW-1:0] exp_rows [N];
    int            exp_cnt;
    bit            exp_done;
    bit            exp_extra;
    bit            active;

    mxv_result_collector #(
        .no_of_eqn_per_cluster(N),
        .element_width(EW),
        .no_of_units(U)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .in_valid(in_valid),
        .in_data(in_data),
        .result_vector(result_vector),
        .beat_count(beat_count),
        .done(done),
        .extra_beat(extra_beat)
    );

    mxv_result_collector #(
        .no_of_eqn_per_cluster(N8),
        .element_width(EW),
        .no_of_units(U)
    ) dut8 (
        .clk(clk),
        .reset(reset),
        .start(start8),
        .in_valid(in_valid8),
        .in_data(in_data8),
        .result_vector(result_vector8),
        .beat_count(beat_count8),
        .done(done8),
        .extra_beat(extra_beat8)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [EW*U-1:0] make_beat(input logic [EW-1:0] a, input logic [EW-1:0] b,
                                                  input logic [EW-1:0] c, input logic [EW-1:0] d);
        return {a, b, c, d};
    endfunction

    function automatic logic [EW*U-1:0] random_beat();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [EW*N-1:0] expected_vector();
        logic [EW*N-1:0] v;
        v = '0;
        for (int r = 0; r < N; r++) v[EW*(N-r)-1 -: EW] = exp_rows[r];
        return v;
    endfunction

    task automatic clear_model_rows();
        for (int r = 0; r < N; r++) exp_rows[r] = '0;
    endtask

    // Beat k holds rows 4k..4k+3; anything from row 10 upward is padding.
    task automatic model_accept(input logic [EW*U-1:0] d);
        for (int j = 0; j < U; j++) begin
            int r;
            r = exp_cnt * U + j;
            if (r < N) exp_rows[r] = d[EW*(U-j)-1 -: EW];
        end
        exp_cnt  = exp_cnt + 1;
        exp_done = (exp_cnt == NB);
    endtask

    task automatic send_beat(input logic [EW*U-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        in_data  = random_beat();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        start8 = 1'b0;
        in_valid8 = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        in_data  = random_beat();
        in_data8 = random_beat();
        do_reset();
        checks++;
        if (result_vector !== '0) begin
            errors++;
            $display("[TB] FAIL reset_vector: got %0h expected 0", result_vector);
        end
        checks++;
        if (beat_count !== '0) begin
            errors++;
            $display("[TB] FAIL reset_count: got %0d expected 0", beat_count);
        end
        checks++;
        if (done !== 1'b0 || extra_beat !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got done=%b extra=%b expected 0 0", done, extra_beat);
        end
    endtask

    task automatic test_basic_session();
        logic [EW*U-1:0] beats [NB];
        beats[0] = make_beat(1, 2, 3, 4);
        beats[1] = make_beat(5, 6, 7, 8);
        beats[2] = make_beat(9, 10, 11, 12);
        start = 1'b1;
        tick();
        for (int k = 0; k < NB; k++) begin
            idle_cycles($urandom_range(0, 2));
            send_beat(beats[k]);
            checks++;
            if (beat_count !== CW'(k + 1)) begin
                errors++;
                $display("[TB] FAIL basic_count%0d: got %0d expected %0d", k, beat_count, k + 1);
            end
            checks++;
            if (done !== (k == NB - 1)) begin
                errors++;
                $display("[TB] FAIL basic_done%0d: got %b expected %b", k, done, k == NB - 1);
            end
        end
        for (int r = 0; r < N; r++) begin
            checks++;
            if (result_vector[EW*(N-r)-1 -: EW] !== EW'(r + 1)) begin
                errors++;
                $display("[TB] FAIL basic_row%0d: got %0d expected %0d", r, result_vector[EW*(N-r)-1 -: EW], r + 1);
            end
        end
        start = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_start_with_valid();
        logic [EW*N-1:0] expv;
        expv = '0;
        for (int r = 0; r < U; r++) expv[EW*(N-r)-1 -: EW] = 7;
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = make_beat(7, 7, 7, 7);
        tick();
        in_valid = 1'b0;
        checks++;
        if (result_vector !== expv) begin
            errors++;
            $display("[TB] FAIL startvalid_vector: got %0h expected %0h", result_vector, expv);
        end
        checks++;
        if (beat_count !== CW'(1)) begin
            errors++;
            $display("[TB] FAIL startvalid_count: got %0d expected 1", beat_count);
        end
        start = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_extra_beat();
        logic [EW*N-1:0] held;
        exp_cnt = 0;
        clear_model_rows();
        start = 1'b1;
        tick();
        for (int k = 0; k < NB; k++) begin
            logic [EW*U-1:0] d;
            d = random_beat();
            model_accept(d);
            send_beat(d);
        end
        held = expected_vector();
        send_beat(make_beat(99, 99, 99, 99));
        checks++;
        if (result_vector !== held) begin
            errors++;
            $display("[TB] FAIL extra_vector: got %0h expected %0h", result_vector, held);
        end
        checks++;
        if (extra_beat !== 1'b1 || done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL extra_flags: got extra=%b done=%b expected 1 1", extra_beat, done);
        end
        checks++;
        if (beat_count !== CW'(NB)) begin
            errors++;
            $display("[TB] FAIL extra_count: got %0d expected %0d", beat_count, NB);
        end
        start = 1'b0;
        tick();
        checks++;
        if (done !== 1'b0 || extra_beat !== 1'b0) begin
            errors++;
            $display("[TB] FAIL extra_clear: got done=%b extra=%b expected 0 0", done, extra_beat);
        end
        tick();
        checks++;
        if (beat_count !== '0 || result_vector !== held) begin
            errors++;
            $display("[TB] FAIL extra_idle: got count=%0d vector=%0h expected 0 %0h", beat_count, result_vector, held);
        end
    endtask

    task automatic test_abort();
        logic [EW*N-1:0] partial;
        exp_cnt = 0;
        clear_model_rows();
        start = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            logic [EW*U-1:0] d;
            d = random_beat();
            model_accept(d);
            send_beat(d);
        end
        partial = expected_vector();
        checks++;
        if (beat_count !== CW'(2)) begin
            errors++;
            $display("[TB] FAIL abort_precount: got %0d expected 2", beat_count);
        end
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = random_beat();
        tick();
        in_valid = 1'b0;
        checks++;
        if (beat_count !== '0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_count: got count=%0d done=%b expected 0 0", beat_count, done);
        end
        checks++;
        if (result_vector !== partial) begin
            errors++;
            $display("[TB] FAIL abort_keep: got %0h expected %0h", result_vector, partial);
        end
        start = 1'b1;
        tick();
        checks++;
        if (result_vector !== '0) begin
            errors++;
            $display("[TB] FAIL abort_restart_clear: got %0h expected 0", result_vector);
        end
        exp_cnt = 0;
        clear_model_rows();
        for (int k = 0; k < NB; k++) begin
            logic [EW*U-1:0] d;
            d = random_beat();
            model_accept(d);
            idle_cycles($urandom_range(0, 1));
            send_beat(d);
        end
        checks++;
        if (result_vector !== expected_vector() || done !== 1'b1 || beat_count !== CW'(NB)) begin
            errors++;
            $display("[TB] FAIL abort_fresh: got %0h done=%b count=%0d expected %0h 1 %0d",
                     result_vector, done, beat_count, expected_vector(), NB);
        end
        start = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_collect();
        start = 1'b1;
        tick();
        send_beat(random_beat());
        send_beat(random_beat());
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = random_beat();
        tick();
        checks++;
        if (result_vector !== '0 || beat_count !== '0 || done !== 1'b0 || extra_beat !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: got vec=%0h count=%0d done=%b extra=%b expected all 0",
                     result_vector, beat_count, done, extra_beat);
        end
        tick();
        checks++;
        if (result_vector !== '0 || beat_count !== '0) begin
            errors++;
            $display("[TB] FAIL midreset_hold: got vec=%0h count=%0d expected 0 0", result_vector, beat_count);
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        start    = 1'b0;
        tick();
    endtask

    task automatic test_divisible();
        logic [EW*N8-1:0] expv;
        logic [EW*U-1:0]  d;
        expv   = '0;
        start8 = 1'b1;
        tick();
        for (int k = 0; k < NB8; k++) begin
            d = random_beat();
            for (int j = 0; j < U; j++) expv[EW*(N8-(k*U+j))-1 -: EW] = d[EW*(U-j)-1 -: EW];
            in_valid8 = 1'b1;
            in_data8  = d;
            tick();
            in_valid8 = 1'b0;
            checks++;
            if (done8 !== (k == NB8 - 1) || beat_count8 !== CW8'(k + 1)) begin
                errors++;
                $display("[TB] FAIL div_beat%0d: got done=%b count=%0d expected %b %0d",
                         k, done8, beat_count8, k == NB8 - 1, k + 1);
            end
        end
        checks++;
        if (result_vector8 !== expv) begin
            errors++;
            $display("[TB] FAIL div_vector: got %0h expected %0h", result_vector8, expv);
        end
        start8 = 1'b0;
        tick();
    endtask

    // Cycle-by-cycle comparison against the session model under random start/valid/reset.
    task automatic test_random();
        do_reset();
        clear_model_rows();
        exp_cnt   = 0;
        exp_done  = 1'b0;
        exp_extra = 1'b0;
        active    = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic [EW*U-1:0] d;
            d        = random_beat();
            reset    = ($urandom_range(0, 59) == 0);
            start    = ($urandom_range(0, 11) != 0);
            in_valid = $urandom_range(0, 1);
            in_data  = d;
            if (reset) begin
                clear_model_rows();
                exp_cnt = 0; exp_done = 1'b0; exp_extra = 1'b0; active = 1'b0;
            end else if (!start) begin
                exp_cnt = 0; exp_done = 1'b0; exp_extra = 1'b0; active = 1'b0;
            end else begin
                if (!active) begin
                    clear_model_rows();
                    exp_cnt = 0;
                    active  = 1'b1;
                end
                if (in_valid) begin
                    if (exp_cnt == NB) exp_extra = 1'b1;
                    else model_accept(d);
                end
            end
            tick();
            checks++;
            if (result_vector !== expected_vector() || beat_count !== exp_cnt[CW-1:0] ||
                done !== exp_done || extra_beat !== exp_extra) begin
                errors++;
                $display("[TB] FAIL random_cycle%0d: got vec=%0h count=%0d done=%b extra=%b expected %0h %0d %b %b",
                         cyc, result_vector, beat_count, done, extra_beat,
                         expected_vector(), exp_cnt, exp_done, exp_extra);
            end
        end
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_session();
        test_start_with_valid();
        test_extra_beat();
        test_abort();
        test_reset_mid_collect();
        test_divisible();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation timeout");
    end

endmodule
